// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the program counter, presents it to instruction memory
// and loads the returned word plus PC+4 into the IF/ID pipeline register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 128,
  parameter int          CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  output logic [31:0]      InstrAddress,
  input  logic [31:0]      InstrIn,
  output logic [31:0]      IFID_Instruction,
  output logic [31:0]      IFID_PCPlus4,
  output logic             IFID_Valid,
  output logic             FetchFault,
  output logic [CNT_W-1:0] FetchCount
);

  // Byte limit is kept 33 bits wide so a 2^30-word memory still compares correctly.
  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        out_of_range;

  assign InstrAddress = pc;
  assign pc_plus4     = pc + 32'd4;
  assign out_of_range = {1'b0, pc} >= PC_LIMIT;

  // Priority: reset, sticky fault, redirect, range fault, stall, then a normal fetch.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc               <= RESET_PC;
      IFID_Instruction <= 32'd0;
      IFID_PCPlus4     <= 32'd0;
      IFID_Valid       <= 1'b0;
      FetchFault       <= 1'b0;
      FetchCount       <= '0;
    end else if (FetchFault) begin
      IFID_Valid       <= 1'b0;
      IFID_Instruction <= 32'd0;
    end else if (BranchTaken) begin
      pc               <= {BranchTarget[31:2], 2'b00};
      IFID_Instruction <= 32'd0;
      IFID_PCPlus4     <= 32'd0;
      IFID_Valid       <= 1'b0;
    end else if (out_of_range) begin
      // Checked even while stalled so a bad target cannot hide behind a hazard.
      FetchFault       <= 1'b1;
      IFID_Valid       <= 1'b0;
      IFID_Instruction <= 32'd0;
    end else if (!Stall) begin
      pc               <= pc_plus4;
      IFID_Instruction <= InstrIn;
      IFID_PCPlus4     <= pc_plus4;
      IFID_Valid       <= 1'b1;
      if (FetchCount != {CNT_W{1'b1}}) begin
        FetchCount <= FetchCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory word i holds i*3.
// A second instance with a 4-bit counter exercises saturation.
module tb_instruction_fetch_unit;

  localparam int MEM_WORDS = 128;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic [31:0] InstrAddress;
  logic [31:0] InstrIn;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        FetchFault;
  logic [15:0] FetchCount;

  logic [31:0] sat_address;
  logic [31:0] sat_instr_in;
  logic [31:0] sat_instruction;
  logic [31:0] sat_pcplus4;
  logic        sat_valid;
  logic        sat_fault;
  logic [3:0]  sat_count;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  // Instruction memory model: word i = i*3, zero outside the legal range.
  assign InstrIn      = (InstrAddress < MEM_WORDS * 4) ? (InstrAddress >> 2) * 32'd3 : 32'd0;
  assign sat_instr_in = (sat_address < MEM_WORDS * 4) ? (sat_address >> 2) * 32'd3 : 32'd0;

  instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .InstrAddress(InstrAddress), .InstrIn(InstrIn),
    .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid), .FetchFault(FetchFault), .FetchCount(FetchCount)
  );

  instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS), .CNT_W(4)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .InstrAddress(sat_address), .InstrIn(sat_instr_in),
    .IFID_Instruction(sat_instruction), .IFID_PCPlus4(sat_pcplus4),
    .IFID_Valid(sat_valid), .FetchFault(sat_fault), .FetchCount(sat_count)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0;
    tick(); tick();
    checks++; if (InstrAddress !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h exp %h", InstrAddress, 32'h0); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", IFID_Valid); end
    checks++; if (IFID_Instruction !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h exp 0", IFID_Instruction); end
    checks++; if (IFID_PCPlus4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_pcplus4 got %h exp 0", IFID_PCPlus4); end
    checks++; if (FetchFault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got %b exp 0", FetchFault); end
    checks++; if (FetchCount !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", FetchCount); end
    Reset = 1'b1;
  endtask

  task automatic test_sequential_fetch();
    logic [31:0] exp_instr [4] = '{32'd0, 32'd3, 32'd6, 32'd9};
    logic [31:0] exp_pc4   [4] = '{32'd4, 32'd8, 32'd12, 32'd16};
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (IFID_Instruction !== exp_instr[i]) begin errors++; $display("[TB] FAIL seq_instr[%0d] got %0d exp %0d", i, IFID_Instruction, exp_instr[i]); end
      checks++; if (IFID_PCPlus4 !== exp_pc4[i]) begin errors++; $display("[TB] FAIL seq_pcplus4[%0d] got %h exp %h", i, IFID_PCPlus4, exp_pc4[i]); end
      checks++; if (IFID_Valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid[%0d] got %b exp 1", i, IFID_Valid); end
    end
    checks++; if (FetchCount !== 16'd4) begin errors++; $display("[TB] FAIL seq_count got %0d exp 4", FetchCount); end
    checks++; if (InstrAddress !== 32'h10) begin errors++; $display("[TB] FAIL seq_pc got %h exp %h", InstrAddress, 32'h10); end
  endtask

  task automatic test_stall();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (InstrAddress !== 32'h10) begin errors++; $display("[TB] FAIL stall_pc[%0d] got %h exp %h", i, InstrAddress, 32'h10); end
      checks++; if (IFID_Instruction !== 32'd9) begin errors++; $display("[TB] FAIL stall_instr[%0d] got %0d exp 9", i, IFID_Instruction); end
      checks++; if (FetchCount !== 16'd4) begin errors++; $display("[TB] FAIL stall_count[%0d] got %0d exp 4", i, FetchCount); end
    end
    Stall = 1'b0;
    tick();
    checks++; if (IFID_Instruction !== 32'd12) begin errors++; $display("[TB] FAIL unstall_instr got %0d exp 12", IFID_Instruction); end
    checks++; if (IFID_PCPlus4 !== 32'h14) begin errors++; $display("[TB] FAIL unstall_pcplus4 got %h exp %h", IFID_PCPlus4, 32'h14); end
    checks++; if (FetchCount !== 16'd5) begin errors++; $display("[TB] FAIL unstall_count got %0d exp 5", FetchCount); end
  endtask

  task automatic test_redirect();
    Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h0000_0043;
    tick();
    Stall = 1'b0; BranchTaken = 1'b0;
    checks++; if (InstrAddress !== 32'h40) begin errors++; $display("[TB] FAIL redir_pc got %h exp %h", InstrAddress, 32'h40); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid got %b exp 0", IFID_Valid); end
    checks++; if (IFID_Instruction !== 32'h0) begin errors++; $display("[TB] FAIL redir_instr got %h exp 0", IFID_Instruction); end
    checks++; if (IFID_PCPlus4 !== 32'h0) begin errors++; $display("[TB] FAIL redir_pcplus4 got %h exp 0", IFID_PCPlus4); end
    checks++; if (FetchCount !== 16'd5) begin errors++; $display("[TB] FAIL redir_count got %0d exp 5", FetchCount); end
    tick();
    checks++; if (IFID_Instruction !== 32'd48) begin errors++; $display("[TB] FAIL target_instr got %0d exp 48", IFID_Instruction); end
    checks++; if (IFID_PCPlus4 !== 32'h44) begin errors++; $display("[TB] FAIL target_pcplus4 got %h exp %h", IFID_PCPlus4, 32'h44); end
    checks++; if (IFID_Valid !== 1'b1) begin errors++; $display("[TB] FAIL target_valid got %b exp 1", IFID_Valid); end
    checks++; if (FetchCount !== 16'd6) begin errors++; $display("[TB] FAIL target_count got %0d exp 6", FetchCount); end
  endtask

  task automatic test_boundary();
    BranchTaken = 1'b1; BranchTarget = 32'h1FC;
    tick();
    BranchTaken = 1'b0;
    tick();
    checks++; if (IFID_Instruction !== 32'd381) begin errors++; $display("[TB] FAIL last_instr got %0d exp 381", IFID_Instruction); end
    checks++; if (InstrAddress !== 32'h200) begin errors++; $display("[TB] FAIL last_pc got %h exp %h", InstrAddress, 32'h200); end
    checks++; if (FetchFault !== 1'b0) begin errors++; $display("[TB] FAIL early_fault got %b exp 0", FetchFault); end
    tick();
    checks++; if (FetchFault !== 1'b1) begin errors++; $display("[TB] FAIL fault_set got %b exp 1", FetchFault); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("[TB] FAIL fault_valid got %b exp 0", IFID_Valid); end
    checks++; if (IFID_Instruction !== 32'h0) begin errors++; $display("[TB] FAIL fault_instr got %h exp 0", IFID_Instruction); end
    checks++; if (InstrAddress !== 32'h200) begin errors++; $display("[TB] FAIL fault_pc got %h exp %h", InstrAddress, 32'h200); end
    BranchTaken = 1'b1; BranchTarget = 32'h20;
    tick();
    BranchTaken = 1'b0;
    checks++; if (InstrAddress !== 32'h200) begin errors++; $display("[TB] FAIL fault_ignore_pc got %h exp %h", InstrAddress, 32'h200); end
    checks++; if (FetchFault !== 1'b1) begin errors++; $display("[TB] FAIL fault_sticky got %b exp 1", FetchFault); end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    checks++; if (FetchFault !== 1'b0) begin errors++; $display("[TB] FAIL fault_clear got %b exp 0", FetchFault); end
    checks++; if (InstrAddress !== 32'h0) begin errors++; $display("[TB] FAIL fault_reset_pc got %h exp 0", InstrAddress); end
  endtask

  task automatic test_stalled_range_fault();
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0204;
    tick();
    BranchTaken = 1'b0; Stall = 1'b1;
    checks++; if (FetchFault !== 1'b0) begin errors++; $display("[TB] FAIL stall_range_pre got %b exp 0", FetchFault); end
    tick();
    Stall = 1'b0;
    checks++; if (FetchFault !== 1'b1) begin errors++; $display("[TB] FAIL stall_range_fault got %b exp 1", FetchFault); end
    checks++; if (InstrAddress !== 32'h204) begin errors++; $display("[TB] FAIL stall_range_pc got %h exp %h", InstrAddress, 32'h204); end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  task automatic test_reset_mid_operation();
    tick(); tick();
    checks++; if (IFID_Valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_valid got %b exp 1", IFID_Valid); end
    Reset = 1'b0; Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h80;
    tick();
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0;
    checks++; if (InstrAddress !== 32'h0) begin errors++; $display("[TB] FAIL mid_pc got %h exp 0", InstrAddress); end
    checks++; if (IFID_Instruction !== 32'h0) begin errors++; $display("[TB] FAIL mid_instr got %h exp 0", IFID_Instruction); end
    checks++; if (IFID_PCPlus4 !== 32'h0) begin errors++; $display("[TB] FAIL mid_pcplus4 got %h exp 0", IFID_PCPlus4); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got %b exp 0", IFID_Valid); end
    checks++; if (FetchCount !== 16'd0) begin errors++; $display("[TB] FAIL mid_count got %0d exp 0", FetchCount); end
  endtask

  task automatic test_count_saturation();
    for (int i = 0; i < 20; i++) tick();
    checks++; if (sat_count !== 4'd15) begin errors++; $display("[TB] FAIL sat_count got %0d exp 15", sat_count); end
    checks++; if (FetchCount !== 16'd20) begin errors++; $display("[TB] FAIL wide_count got %0d exp 20", FetchCount); end
    checks++; if (sat_address !== 32'd80) begin errors++; $display("[TB] FAIL sat_pc got %h exp %h", sat_address, 32'd80); end
    BranchTaken = 1'b1; BranchTarget = 32'h8;
    tick();
    BranchTaken = 1'b0;
    checks++; if (FetchCount !== 16'd20) begin errors++; $display("[TB] FAIL redir_no_count got %0d exp 20", FetchCount); end
    checks++; if (sat_count !== 4'd15) begin errors++; $display("[TB] FAIL sat_hold got %0d exp 15", sat_count); end
    tick();
    checks++; if (FetchCount !== 16'd21) begin errors++; $display("[TB] FAIL post_redir_count got %0d exp 21", FetchCount); end
    checks++; if (IFID_Instruction !== 32'd6) begin errors++; $display("[TB] FAIL post_redir_instr got %0d exp 6", IFID_Instruction); end
  endtask

  initial begin
    test_reset();
    test_sequential_fetch();
    test_stall();
    test_redirect();
    test_boundary();
    test_stalled_range_fault();
    test_reset_mid_operation();
    test_count_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
